// File: rtl/gp_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gp_reg_pkg
// Purpose  : Shared definitions for the general-purpose register file:
//            default parameter values and the 3-bit controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package gp_reg_pkg;

    localparam int DEF_DATA  = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_ADDR  = 4;
    localparam int DEF_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_CLR   = 3'd2,
        ST_SWEEP = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

endpackage : gp_reg_pkg
`default_nettype wire

// File: rtl/gp_reg_merge.sv
`default_nettype none
// ============================================================================
// Module   : gp_reg_merge
// Purpose  : Combinational lane-masked merge. Each lane of the result comes
//            from new_data when its lane_en bit is set, else from old_data.
// Ports    : old_data  - current register contents
//            new_data  - incoming write data
//            lane_en   - one enable bit per lane
//            merged    - resulting word
// Revision : 1.0 - initial release
// ============================================================================
module gp_reg_merge
    import gp_reg_pkg::*;
#(
    parameter int PA_DATA  = DEF_DATA,
    parameter int PA_LANES = DEF_LANES
) (
    input  logic [PA_DATA-1:0]  old_data,
    input  logic [PA_DATA-1:0]  new_data,
    input  logic [PA_LANES-1:0] lane_en,
    output logic [PA_DATA-1:0]  merged
);

    localparam int LW = PA_DATA / PA_LANES;

    for (genvar i = 0; i < PA_LANES; i++) begin : g_lane
        assign merged[i*LW +: LW] = lane_en[i] ? new_data[i*LW +: LW]
                                               : old_data[i*LW +: LW];
    end

endmodule : gp_reg_merge
`default_nettype wire

// File: rtl/gp_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : gp_reg_file
// Purpose  : Flip-flop register file with lane-masked writes, single-address
//            clear and a whole-file sweep clear, two registered read ports.
//            Write/clear requests are accepted only while idle; each
//            operation finishes with a one-cycle ack pulse.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            wr_req, clr_req      - write / clear requests (clear wins)
//            clr_all              - with clr_req, clear every register
//            addr, data_in,
//            lane_en              - write/clear target, data, lane enables
//            rd_addr_a/b          - read addresses
//            rd_data_a/b          - registered read data (1-cycle latency)
//            busy                 - high whenever the controller is not idle
//            ack                  - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module gp_reg_file
    import gp_reg_pkg::*;
#(
    parameter int PA_DATA  = DEF_DATA,
    parameter int PA_DEPTH = DEF_DEPTH,
    parameter int PA_ADDR  = DEF_ADDR,
    parameter int PA_LANES = DEF_LANES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req,
    input  logic                clr_req,
    input  logic                clr_all,
    input  logic [PA_ADDR-1:0]  addr,
    input  logic [PA_DATA-1:0]  data_in,
    input  logic [PA_LANES-1:0] lane_en,
    input  logic [PA_ADDR-1:0]  rd_addr_a,
    input  logic [PA_ADDR-1:0]  rd_addr_b,
    output logic [PA_DATA-1:0]  rd_data_a,
    output logic [PA_DATA-1:0]  rd_data_b,
    output logic                busy,
    output logic                ack
);

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic                  sweep_last;
    logic [PA_ADDR-1:0]    sweep_cnt;
    logic [PA_ADDR-1:0]    cap_addr;
    logic [PA_DATA-1:0]    cap_data;
    logic [PA_LANES-1:0]   cap_lane;
    logic [PA_DATA-1:0]    mem [PA_DEPTH];
    logic [PA_DATA-1:0]    old_word;
    logic [PA_DATA-1:0]    merged_word;
    logic [PA_DATA-1:0]    rd_a_nxt;
    logic [PA_DATA-1:0]    rd_b_nxt;

    assign sweep_last = (sweep_cnt == PA_ADDR'(PA_DEPTH - 1));

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The clr_all choice is resolved at acceptance into CLR vs SWEEP, so the
    // state itself carries the captured clr_all for the rest of the operation.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b1;
        ack       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (clr_req) begin
                    accept    = 1'b1;
                    state_nxt = clr_all ? ST_SWEEP : ST_CLR;
                end else if (wr_req) begin
                    accept    = 1'b1;
                    state_nxt = ST_WR;
                end
            end
            ST_WR:    state_nxt = ST_ACK;
            ST_CLR:   state_nxt = ST_ACK;
            ST_SWEEP: if (sweep_last) state_nxt = ST_ACK;
            ST_ACK: begin
                ack       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields are frozen at acceptance so input changes while busy
    // cannot disturb the operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr <= '0;
            cap_data <= '0;
            cap_lane <= '0;
        end else if (accept) begin
            cap_addr <= addr;
            cap_data <= data_in;
            cap_lane <= lane_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt <= '0;
        end else if (accept) begin
            sweep_cnt <= '0;
        end else if ((state == ST_SWEEP) && !sweep_last) begin
            sweep_cnt <= sweep_cnt + PA_ADDR'(1);
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Address decode by comparison: an out-of-range address matches no
    // register, so it writes/clears nothing and reads back as zero.
    always_comb begin
        old_word = '0;
        for (int i = 0; i < PA_DEPTH; i++) begin
            if (cap_addr == PA_ADDR'(i)) old_word = mem[i];
        end
    end

    gp_reg_merge #(
        .PA_DATA  (PA_DATA),
        .PA_LANES (PA_LANES)
    ) u_merge (
        .old_data (old_word),
        .new_data (cap_data),
        .lane_en  (cap_lane),
        .merged   (merged_word)
    );

    for (genvar g = 0; g < PA_DEPTH; g++) begin : g_reg
        logic               wr_hit;
        logic               clr_hit;
        logic [PA_DATA-1:0] q;

        assign wr_hit  = (state == ST_WR) && (cap_addr == PA_ADDR'(g));
        assign clr_hit = ((state == ST_CLR)   && (cap_addr  == PA_ADDR'(g))) ||
                         ((state == ST_SWEEP) && (sweep_cnt == PA_ADDR'(g)));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
            end else if (wr_hit) begin
                q <= merged_word;
            end else if (clr_hit) begin
                q <= '0;
            end
        end

        assign mem[g] = q;
    end

    // ------------------------------------------------------------------
    // Read ports: sampled from pre-edge storage, so a same-edge write to the
    // read address returns the old contents.
    // ------------------------------------------------------------------
    always_comb begin
        rd_a_nxt = '0;
        rd_b_nxt = '0;
        for (int i = 0; i < PA_DEPTH; i++) begin
            if (rd_addr_a == PA_ADDR'(i)) rd_a_nxt = mem[i];
            if (rd_addr_b == PA_ADDR'(i)) rd_b_nxt = mem[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= rd_a_nxt;
            rd_data_b <= rd_b_nxt;
        end
    end

endmodule : gp_reg_file
`default_nettype wire

// File: tb/tb_gp_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_gp_reg_file
// Purpose  : Self-checking bench for gp_reg_file. A driver issues stimulus and
//            pushes the expected post-edge outputs into a queue; a monitor
//            pops and compares on the falling edge. A second instance with
//            12 registers exercises out-of-range addressing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gp_reg_file;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        wr_req, clr_req, clr_all;
    logic [3:0]  addr, lane_en, rd_addr_a, rd_addr_b;
    logic [31:0] data_in, rd_data_a, rd_data_b;
    logic        busy, ack;

    logic        d12_wr, d12_clr, d12_all;
    logic [3:0]  d12_addr, d12_lane, d12_ra, d12_rb;
    logic [31:0] d12_data, d12_rda, d12_rdb;
    logic        d12_busy, d12_ack;

    gp_reg_file dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .clr_req(clr_req),
        .clr_all(clr_all), .addr(addr), .data_in(data_in), .lane_en(lane_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .busy(busy), .ack(ack)
    );

    gp_reg_file #(.PA_DEPTH(12)) dut12 (
        .clk(clk), .rst(rst), .wr_req(d12_wr), .clr_req(d12_clr),
        .clr_all(d12_all), .addr(d12_addr), .data_in(d12_data), .lane_en(d12_lane),
        .rd_addr_a(d12_ra), .rd_addr_b(d12_rb),
        .rd_data_a(d12_rda), .rd_data_b(d12_rdb), .busy(d12_busy), .ack(d12_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus the one operation in flight,
    // described by its acceptance edge and its length in edges.
    logic [31:0] mm [DEPTH];
    bit          op_valid;
    int          op_kind;      // 0 write, 1 clear one, 2 clear all
    int          op_t, op_len, op_addr;
    logic [31:0] op_data;
    logic [3:0]  op_lanes;
    int          free_edge;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ack;
        logic        busy;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h t=%0t", nm, got, want, $time);
        end
    endtask

    // One clock of stimulus: set inputs, predict the outputs after the next
    // edge, advance the model across that edge, then wait past it.
    task automatic cd(input bit w, input bit c, input bit all,
                      input logic [3:0] a, input logic [31:0] d, input logic [3:0] l,
                      input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        int   en;
        en        = edge_cnt + 1;
        wr_req    = w;
        clr_req   = c;
        clr_all   = all;
        addr      = a;
        data_in   = d;
        lane_en   = l;
        rd_addr_a = ra;
        rd_addr_b = rb;
        e.a = mm[ra];
        e.b = mm[rb];
        if (op_valid && en > op_t) begin
            if (op_kind == 0 && en == op_t + 1) begin
                for (int i = 0; i < 4; i++)
                    if (op_lanes[i]) mm[op_addr][8*i +: 8] = op_data[8*i +: 8];
            end else if (op_kind == 1 && en == op_t + 1) begin
                mm[op_addr] = 32'h0;
            end else if (op_kind == 2 && en <= op_t + DEPTH) begin
                mm[en - op_t - 1] = 32'h0;
            end
        end
        if ((w || c) && en >= free_edge) begin
            op_valid  = 1'b1;
            op_t      = en;
            op_kind   = c ? (all ? 2 : 1) : 0;
            op_len    = (op_kind == 2) ? DEPTH : 1;
            op_addr   = int'(a);
            op_data   = d;
            op_lanes  = l;
            free_edge = en + op_len + 2;
        end
        e.ack  = op_valid && (en == op_t + op_len);
        e.busy = op_valid && (en >= op_t) && (en <= op_t + op_len);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
        cd(1'b0, 1'b0, 1'b0, 4'($urandom), $urandom, 4'($urandom), ra, rb);
    endtask

    // Write then two idle cycles; reports ack seen after the first idle.
    task automatic wr_op(input logic [3:0] a, input logic [31:0] d, input logic [3:0] l,
                         output logic ack_seen);
        cd(1'b1, 1'b0, 1'b0, a, d, l, a, a);
        idle(a, a);
        ack_seen = ack;
        idle(a, a);
    endtask

    task automatic d12_cycle(input bit w, input bit c, input logic [3:0] a,
                             input logic [31:0] d, input logic [3:0] ra);
        d12_wr   = w;
        d12_clr  = c;
        d12_addr = a;
        d12_data = d;
        d12_ra   = ra;
        d12_rb   = ra;
        idle(4'd0, 4'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},  32'(ack),  32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_rda"},  rd_data_a, 32'h0);
        chk({tag, "_rdb"},  rd_data_b, 32'h0);
        chk({tag, "_d12_ack"},  32'(d12_ack),  32'h0);
        chk({tag, "_d12_busy"}, 32'(d12_busy), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        wr_req = 1'b0; clr_req = 1'b0; clr_all = 1'b0;
        d12_wr = 1'b0; d12_clr = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
        op_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        free_edge = edge_cnt + 1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_rd_a", rd_data_a, e.a);
                chk("sb_rd_b", rd_data_b, e.b);
                chk("sb_ack",  32'(ack),  32'(e.ack));
                chk("sb_busy", 32'(busy), 32'(e.busy));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        logic ack_seen;
        int   busy_cnt;
        rst = 1'b1;
        wr_req = 1'b0; clr_req = 1'b0; clr_all = 1'b0;
        addr = '0; data_in = '0; lane_en = '0; rd_addr_a = '0; rd_addr_b = '0;
        d12_wr = 1'b0; d12_clr = 1'b0; d12_all = 1'b0; d12_addr = '0;
        d12_data = '0; d12_lane = 4'hF; d12_ra = '0; d12_rb = '0;
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        #1;
        rst = 1'b0;
        free_edge = edge_cnt + 1;

        // Full write at addr 3, issued on the first edge after reset release.
        cd(1'b1, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 4'hF, 4'd3, 4'd3);
        chk("wr3_busy", 32'(busy), 32'h1);
        idle(4'd3, 4'd3);
        chk("wr3_ack_hi", 32'(ack), 32'h1);
        chk("wr3_same_edge_old", rd_data_b, 32'h0);
        idle(4'd3, 4'd3);
        chk("wr3_ack_lo", 32'(ack), 32'h0);
        chk("wr3_rd", rd_data_a, 32'hDEADBEEF);

        // Lane-masked writes.
        wr_op(4'd5, 32'h11223344, 4'hF, ack_seen);
        chk("pre5_rd", rd_data_a, 32'h11223344);
        wr_op(4'd5, 32'hAABBCCDD, 4'b0101, ack_seen);
        chk("lane5_rd", rd_data_a, 32'h11BB33DD);
        wr_op(4'd5, 32'h99999999, 4'b0000, ack_seen);
        chk("lane0_ack", 32'(ack_seen), 32'h1);
        chk("lane0_rd", rd_data_a, 32'h11BB33DD);

        // Clear has priority over write.
        wr_op(4'd7, 32'hFFFFFFFF, 4'hF, ack_seen);
        cd(1'b1, 1'b1, 1'b0, 4'd7, 32'h12345678, 4'hF, 4'd7, 4'd7);
        idle(4'd7, 4'd7);
        idle(4'd7, 4'd7);
        chk("prio7_rd", rd_data_a, 32'h0);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            cd(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0,
               4'($urandom), $urandom, 4'($urandom), 4'($urandom), 4'($urandom));
        end
        repeat (20) idle(4'($urandom), 4'($urandom));

        // Sweep clear over a file full of 0xA5A5A5A5, with a mid-sweep write.
        for (int i = 0; i < DEPTH; i++) wr_op(4'(i), 32'hA5A5A5A5, 4'hF, ack_seen);
        cd(1'b0, 1'b1, 1'b1, 4'd0, 32'h0, 4'h0, 4'd0, 4'd0);
        busy_cnt = busy ? 1 : 0;
        for (int k = 0; k < 17; k++) begin
            cd(k == 5, 1'b0, 1'b0, 4'd9, 32'h5A5A5A5A, 4'hF, 4'd9, 4'd9);
            if (busy) busy_cnt++;
        end
        chk("sweep_busy_cycles", 32'(busy_cnt), 32'd17);
        for (int i = 0; i < DEPTH; i++) idle(4'(i), 4'(15 - i));
        idle(4'd9, 4'd9);
        chk("sweep_rd9", rd_data_a, 32'h0);

        // Reset in the middle of a sweep.
        wr_op(4'd1, 32'h01010101, 4'hF, ack_seen);
        wr_op(4'd14, 32'h0E0E0E0E, 4'hF, ack_seen);
        cd(1'b0, 1'b1, 1'b1, 4'd0, 32'h0, 4'h0, 4'd14, 4'd1);
        repeat (5) idle(4'd14, 4'd1);
        do_reset();
        cd(1'b1, 1'b0, 1'b0, 4'd2, 32'h55AA55AA, 4'hF, 4'd14, 4'd1);
        chk("post_rst_accept_busy", 32'(busy), 32'h1);
        for (int i = 0; i < DEPTH; i++) idle(4'(i), 4'(i));

        // 12-deep instance: out-of-range write and clear.
        d12_cycle(1'b1, 1'b0, 4'd11, 32'h12345678, 4'd11);
        d12_cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd11);
        d12_cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd11);
        chk("d12_rd11", d12_rda, 32'h12345678);
        d12_cycle(1'b1, 1'b0, 4'd13, 32'hCAFEF00D, 4'd13);
        chk("d12_oor_busy", 32'(d12_busy), 32'h1);
        d12_cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd13);
        chk("d12_oor_ack", 32'(d12_ack), 32'h1);
        d12_cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd13);
        chk("d12_rd13", d12_rda, 32'h0);
        d12_cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd1);
        chk("d12_rd1", d12_rda, 32'h0);
        d12_cycle(1'b0, 1'b1, 4'd15, 32'h0, 4'd11);
        d12_cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd11);
        chk("d12_oor_clr_ack", 32'(d12_ack), 32'h1);
        d12_cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd11);
        chk("d12_rd11_after_clr", d12_rdb, 32'h12345678);

        repeat (3) idle(4'($urandom), 4'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gp_reg_file
`default_nettype wire
